// File: rtl/pcmb_encoder.sv
// ADPCM-B encoder: quantises signed PCM samples to YM2610-style ADPCM-B nibbles and writes packed bytes to V-ROM addresses.
// Define PCMB_ENC_RECON_EN to add the RECON_OUT / RECON_VALID reconstruction outputs.
module pcmb_encoder #(
   parameter int unsigned STEP_INIT = 127,
   parameter int unsigned STEP_MIN  = 127,
   parameter int unsigned STEP_MAX  = 24576
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        START,
   input  logic [15:0] ADDR_START,
   input  logic [15:0] ADDR_STOP,
   input  logic        IN_VALID,
   input  logic [15:0] IN_SAMPLE,
   output logic        IN_READY,
   output logic [21:0] WR_ADDR,
   output logic [7:0]  WR_DATA,
   output logic        WR_EN,
   output logic        END_FLAG,
   output logic        BUSY
`ifdef PCMB_ENC_RECON_EN
   ,
   output logic signed [15:0] RECON_OUT,
   output logic               RECON_VALID
`endif
);

   localparam int unsigned ACC_W  = 16;
   localparam int unsigned STEP_W = 16;
   localparam int unsigned D_W    = 17;
   localparam int unsigned PROD_W = 24;
   localparam int unsigned CNT_W  = 20;
   localparam int unsigned PAGE_W = 12;
   localparam int unsigned PH_W   = 3;

   localparam logic [STEP_W-1:0] STEP_INIT_V = STEP_W'(STEP_INIT);
   localparam logic [PROD_W-1:0] STEP_MIN_V  = PROD_W'(STEP_MIN);
   localparam logic [PROD_W-1:0] STEP_MAX_V  = PROD_W'(STEP_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_DIFF, S_QUANT, S_DNMUL, S_ACCUPD, S_STEPMUL, S_PACK
   } state_t;

   state_t            state_q, next_state;
   logic [PH_W-1:0]   phase_q, next_phase;

   logic                     run_q, run_n;
   logic signed [ACC_W-1:0]  acc_q, acc_n;
   logic [STEP_W-1:0]        step_q, step_n;
   logic                     nib_sel_q, nib_sel_n;
   logic [15:0]              sample_q, sample_n;
   logic                     sgn_q, sgn_n;
   logic [D_W-1:0]           resid_q, resid_n;
   logic [2:0]               mag_q, mag_n;
   logic [PROD_W-1:0]        prod_q, prod_n;
   logic [D_W-1:0]           dn_q, dn_n;
   logic [CNT_W-1:0]         cnt_q, cnt_n;
   logic [1:0]               bank_q, bank_n;
   logic [PAGE_W-1:0]        stop_q, stop_n;

   logic        in_ready_n, wr_en_n, end_n, busy_n;
   logic [21:0] wr_addr_n;
   logic [7:0]  wr_data_n;

   logic                     accept_c;
   logic [D_W-1:0]           diff;
   logic [D_W-1:0]           thr;
   logic [3:0]               mul4;
   logic [7:0]               mult;
   logic [PROD_W-1:0]        addend, sum, scaled;
   logic signed [ACC_W+1:0]  acc_ext, dn_ext, upd;
   logic [3:0]               nib;

`ifdef PCMB_ENC_RECON_EN
   logic signed [15:0] recon_out_n;
   logic               recon_valid_n;
`endif

   logic unused_addr_bits;
   assign unused_addr_bits = ^{ADDR_START[15:14], ADDR_STOP[15:12]};

   assign accept_c = IN_VALID && IN_READY && (state_q == S_IDLE);

   // Step-size multiplier per quantised magnitude, in 1/64 units
   function automatic logic [7:0] mult_lut(input logic [2:0] m);
      case (m)
         3'd4:    mult_lut = 8'd77;
         3'd5:    mult_lut = 8'd102;
         3'd6:    mult_lut = 8'd128;
         3'd7:    mult_lut = 8'd153;
         default: mult_lut = 8'd57;
      endcase
   endfunction

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q <= S_IDLE;
         phase_q <= '0;
      end else begin
         state_q <= next_state;
         phase_q <= next_phase;
      end
   end

   // START abandons any in-flight sample
   always_comb begin
      next_state = state_q;
      next_phase = phase_q;
      if (START) begin
         next_state = S_IDLE;
         next_phase = '0;
      end else begin
         case (state_q)
            S_IDLE:   if (accept_c) next_state = S_DIFF;
            S_DIFF: begin
               next_state = S_QUANT;
               next_phase = '0;
            end
            S_QUANT:
               if (phase_q == 3'd2) begin
                  next_state = S_DNMUL;
                  next_phase = '0;
               end else next_phase = phase_q + 3'd1;
            S_DNMUL:
               if (phase_q == 3'd3) begin
                  next_state = S_ACCUPD;
                  next_phase = '0;
               end else next_phase = phase_q + 3'd1;
            S_ACCUPD: begin
               next_state = S_STEPMUL;
               next_phase = '0;
            end
            S_STEPMUL:
               if (phase_q == 3'd7) begin
                  next_state = S_PACK;
                  next_phase = '0;
               end else next_phase = phase_q + 3'd1;
            S_PACK:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
         endcase
      end
   end

   // Datapath and output next values; outputs land one edge ahead so they line up with the state entered
   always_comb begin
      run_n     = run_q;
      acc_n     = acc_q;
      step_n    = step_q;
      nib_sel_n = nib_sel_q;
      sample_n  = sample_q;
      sgn_n     = sgn_q;
      resid_n   = resid_q;
      mag_n     = mag_q;
      prod_n    = prod_q;
      dn_n      = dn_q;
      cnt_n     = cnt_q;
      bank_n    = bank_q;
      stop_n    = stop_q;
      end_n     = END_FLAG;
      wr_addr_n = WR_ADDR;
      wr_data_n = WR_DATA;
      wr_en_n   = 1'b0;
      diff      = '0;
      thr       = '0;
      mul4      = {mag_q, 1'b1};
      mult      = mult_lut(mag_q);
      addend    = '0;
      sum       = '0;
      scaled    = '0;
      acc_ext   = {{2{acc_q[ACC_W-1]}}, acc_q};
      dn_ext    = {1'b0, dn_q};
      upd       = '0;
      nib       = {sgn_q, mag_q};
`ifdef PCMB_ENC_RECON_EN
      recon_out_n   = RECON_OUT;
      recon_valid_n = 1'b0;
`endif
      if (START) begin
         cnt_n     = {ADDR_START[11:0], 8'h00};
         bank_n    = ADDR_START[13:12];
         stop_n    = ADDR_STOP[11:0];
         acc_n     = '0;
         step_n    = STEP_INIT_V;
         nib_sel_n = 1'b0;
         end_n     = 1'b0;
         run_n     = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (accept_c) sample_n = IN_SAMPLE;
            S_DIFF: begin
               diff    = {sample_q[15], sample_q} - {acc_q[ACC_W-1], acc_q};
               sgn_n   = diff[D_W-1];
               resid_n = diff[D_W-1] ? (~diff + 17'd1) : diff;
               mag_n   = '0;
               prod_n  = '0;
            end
            S_QUANT: begin
               thr = D_W'(step_q >> phase_q);
               if (resid_q >= thr) begin
                  resid_n = resid_q - thr;
                  mag_n   = {mag_q[1:0], 1'b1};
               end else mag_n = {mag_q[1:0], 1'b0};
            end
            S_DNMUL: begin
               addend = mul4[phase_q[1:0]] ? (PROD_W'(step_q) << phase_q) : '0;
               sum    = prod_q + addend;
               prod_n = sum;
               if (phase_q == 3'd3) begin
                  dn_n   = D_W'(sum >> 3);
                  prod_n = '0;
               end
            end
            S_ACCUPD: begin
               upd = sgn_q ? (acc_ext - dn_ext) : (acc_ext + dn_ext);
               if (upd > 18'sd32767)       acc_n = 16'sh7FFF;
               else if (upd < -18'sd32768) acc_n = -16'sh8000;
               else                        acc_n = upd[ACC_W-1:0];
`ifdef PCMB_ENC_RECON_EN
               recon_out_n   = acc_n;
               recon_valid_n = 1'b1;
`endif
            end
            S_STEPMUL: begin
               addend = mult[phase_q] ? (PROD_W'(step_q) << phase_q) : '0;
               sum    = prod_q + addend;
               prod_n = sum;
               if (phase_q == 3'd7) begin
                  prod_n = '0;
                  scaled = sum >> 6;
                  if (scaled < STEP_MIN_V)      step_n = STEP_W'(STEP_MIN_V);
                  else if (scaled > STEP_MAX_V) step_n = STEP_W'(STEP_MAX_V);
                  else                          step_n = STEP_W'(scaled);
                  // Pack decision made here so the write strobe is visible during PACK
                  if (!nib_sel_q) begin
                     wr_data_n[7:4] = nib;
                  end else if (cnt_q[19:8] == stop_q) begin
                     end_n = 1'b1;
                     run_n = 1'b0;
                  end else begin
                     wr_data_n[3:0] = nib;
                     wr_en_n        = 1'b1;
                     wr_addr_n      = {bank_q, cnt_q};
                     cnt_n          = cnt_q + 20'd1;
                  end
                  nib_sel_n = ~nib_sel_q;
               end
            end
            default: ;
         endcase
      end
      in_ready_n = (next_state == S_IDLE) && run_n && !end_n;
      busy_n     = (next_state != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         run_q     <= 1'b0;
         acc_q     <= '0;
         step_q    <= STEP_INIT_V;
         nib_sel_q <= 1'b0;
         sample_q  <= '0;
         sgn_q     <= 1'b0;
         resid_q   <= '0;
         mag_q     <= '0;
         prod_q    <= '0;
         dn_q      <= '0;
         cnt_q     <= '0;
         bank_q    <= '0;
         stop_q    <= '0;
         IN_READY  <= 1'b0;
         WR_EN     <= 1'b0;
         WR_DATA   <= '0;
         WR_ADDR   <= '0;
         END_FLAG  <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         run_q     <= run_n;
         acc_q     <= acc_n;
         step_q    <= step_n;
         nib_sel_q <= nib_sel_n;
         sample_q  <= sample_n;
         sgn_q     <= sgn_n;
         resid_q   <= resid_n;
         mag_q     <= mag_n;
         prod_q    <= prod_n;
         dn_q      <= dn_n;
         cnt_q     <= cnt_n;
         bank_q    <= bank_n;
         stop_q    <= stop_n;
         IN_READY  <= in_ready_n;
         WR_EN     <= wr_en_n;
         WR_DATA   <= wr_data_n;
         WR_ADDR   <= wr_addr_n;
         END_FLAG  <= end_n;
         BUSY      <= busy_n;
      end
   end

`ifdef PCMB_ENC_RECON_EN
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         RECON_OUT   <= '0;
         RECON_VALID <= 1'b0;
      end else begin
         RECON_OUT   <= recon_out_n;
         RECON_VALID <= recon_valid_n;
      end
   end
`endif

endmodule

// File: tb/tb_pcmb_encoder.sv
// Self-checking bench for pcmb_encoder: randomized samples against a behavioural ADPCM-B encoder model.
module tb_pcmb_encoder;
   logic        CLK = 1'b0;
   logic        nRESET, START, IN_VALID;
   logic [15:0] ADDR_START, ADDR_STOP, IN_SAMPLE;
   logic        IN_READY, WR_EN, END_FLAG, BUSY;
   logic [21:0] WR_ADDR;
   logic [7:0]  WR_DATA;
`ifdef PCMB_ENC_RECON_EN
   logic signed [15:0] RECON_OUT;
   logic               RECON_VALID;
   int                 recon_q[$];
`endif

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int m_acc, m_step, m_cnt, m_bank, m_stop, m_hi;
   bit m_sel, m_run, m_end;
   int mult_tab[8] = '{57, 57, 57, 57, 77, 102, 128, 153};

   logic [21:0] dut_wa;
   logic [7:0]  dut_wd;
   int          wr_count = 0;
   logic [21:0] mon_last_addr;
   bit          saw_wrap = 0;
   logic [15:0] abort_as, abort_ast;

   always #5 CLK = ~CLK;

   pcmb_encoder dut (
      .CLK(CLK), .nRESET(nRESET), .START(START),
      .ADDR_START(ADDR_START), .ADDR_STOP(ADDR_STOP),
      .IN_VALID(IN_VALID), .IN_SAMPLE(IN_SAMPLE), .IN_READY(IN_READY),
      .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
      .END_FLAG(END_FLAG), .BUSY(BUSY)
`ifdef PCMB_ENC_RECON_EN
      , .RECON_OUT(RECON_OUT), .RECON_VALID(RECON_VALID)
`endif
   );

   always @(negedge CLK) if (WR_EN === 1'b1) begin
      wr_count++;
      mon_last_addr = WR_ADDR;
      if (WR_ADDR === 22'h200000) saw_wrap = 1;
   end

`ifdef PCMB_ENC_RECON_EN
   always @(negedge CLK) if (RECON_VALID === 1'b1) begin
      int e;
      vectors++;
      if (recon_q.size() == 0) begin
         miscompares++;
         $display("FAIL recon_unexpected: RECON_VALID=1 with RECON_OUT=%0d, required no pulse", RECON_OUT);
      end else begin
         e = recon_q.pop_front();
         if (RECON_OUT !== 16'(e)) begin
            miscompares++;
            $display("FAIL recon_value: RECON_OUT=%0d required %0d", RECON_OUT, e);
         end
      end
   end
`endif

   task automatic model_reset();
      m_acc = 0; m_step = 127; m_sel = 0; m_run = 0; m_end = 0; m_cnt = 0; m_bank = 0; m_hi = 0;
   endtask

   task automatic model_start(input logic [15:0] as, input logic [15:0] ast);
      m_acc = 0; m_step = 127; m_sel = 0; m_run = 1; m_end = 0;
      m_cnt = int'(as[11:0]) * 256;
      m_bank = int'(as[13:12]);
      m_stop = int'(ast[11:0]);
   endtask

   // Encode one sample with plain integer arithmetic and decide what the byte packer does
   task automatic model_sample(input int smp, output bit wr, output int addr, output int data);
      int d, m, mag, thr, dn, nib;
      bit s;
      d = smp - m_acc;
      s = (d < 0);
      m = s ? -d : d;
      mag = 0;
      for (int k = 0; k < 3; k++) begin
         thr = m_step / (1 << k);
         if (m >= thr) begin
            mag += 4 >> k;
            m -= thr;
         end
      end
      dn = (m_step * (2 * mag + 1)) / 8;
      m_acc = s ? m_acc - dn : m_acc + dn;
      if (m_acc > 32767) m_acc = 32767;
      if (m_acc < -32768) m_acc = -32768;
`ifdef PCMB_ENC_RECON_EN
      recon_q.push_back(m_acc);
`endif
      m_step = (m_step * mult_tab[mag]) / 64;
      if (m_step < 127) m_step = 127;
      if (m_step > 24576) m_step = 24576;
      nib = (s ? 8 : 0) + mag;
      wr = 0; addr = 0; data = 0;
      if (!m_sel) m_hi = nib;
      else if ((m_cnt / 256) == m_stop) begin
         m_end = 1;
         m_run = 0;
      end else begin
         wr = 1;
         addr = m_bank * (1 << 20) + m_cnt;
         data = m_hi * 16 + nib;
         m_cnt = (m_cnt + 1) % (1 << 20);
      end
      m_sel = !m_sel;
   endtask

   function automatic int rand_sample();
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) return int'($signed(16'($urandom)));
      if (r == 1) return int'($urandom_range(0, 2000)) - 1000;
      if (r == 2) return int'($urandom_range(0, 20000)) - 10000;
      return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
   endfunction

   task automatic do_start(input logic [15:0] as, input logic [15:0] ast);
      START = 1'b1; ADDR_START = as; ADDR_STOP = ast;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      model_start(as, ast);
      vectors++;
      if ({IN_READY, END_FLAG, BUSY, WR_EN} !== 4'b1000) begin
         miscompares++;
         $display("FAIL start_state: {IN_READY,END_FLAG,BUSY,WR_EN}=%b required 1000", {IN_READY, END_FLAG, BUSY, WR_EN});
      end
   endtask

   // One sample through the pipe; abort_kind 1 = START at cycle abort_at, 2 = reset at cycle abort_at
   task automatic do_sample(input int smp, input bit hold, input int abort_at, input int abort_kind);
      int addr, data, t;
      bit wr;
      logic e_ready, e_busy, e_wr;
      t = 0;
      while (IN_READY !== 1'b1 && t < 60) begin
         @(negedge CLK);
         t++;
      end
      vectors++;
      if (IN_READY !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_wait: IN_READY=%b required 1 within 60 cycles", IN_READY);
         IN_VALID = 1'b0;
         return;
      end
      IN_VALID = 1'b1;
      IN_SAMPLE = 16'(smp);
      wr = 0; addr = 0; data = 0;
      if (abort_kind != 2) model_sample(smp, wr, addr, data);
      if (abort_kind == 1) wr = 0;
      @(posedge CLK);
      for (int k = 1; k <= 19; k++) begin
         @(negedge CLK);
         if (!hold) begin
            IN_VALID = 1'b0;
            IN_SAMPLE = 16'($urandom);
         end
         e_busy  = (k <= 18);
         e_ready = (k == 19) && m_run && !m_end;
         e_wr    = (k == 18) && wr;
         vectors++;
         if (BUSY !== e_busy) begin
            miscompares++;
            $display("FAIL busy c%0d: BUSY=%b required %b", k, BUSY, e_busy);
         end
         vectors++;
         if (IN_READY !== e_ready) begin
            miscompares++;
            $display("FAIL in_ready c%0d: IN_READY=%b required %b", k, IN_READY, e_ready);
         end
         vectors++;
         if (WR_EN !== e_wr) begin
            miscompares++;
            $display("FAIL wr_en c%0d: WR_EN=%b required %b", k, WR_EN, e_wr);
         end
         if (e_wr) begin
            dut_wa = WR_ADDR;
            dut_wd = WR_DATA;
            vectors++;
            if (WR_ADDR !== 22'(addr)) begin
               miscompares++;
               $display("FAIL wr_addr: WR_ADDR=%h required %h", WR_ADDR, 22'(addr));
            end
            vectors++;
            if (WR_DATA !== 8'(data)) begin
               miscompares++;
               $display("FAIL wr_data: WR_DATA=%h required %h (sample %0d)", WR_DATA, 8'(data), smp);
            end
         end
         if (k == 18) begin
            vectors++;
            if (END_FLAG !== m_end) begin
               miscompares++;
               $display("FAIL end_flag: END_FLAG=%b required %b", END_FLAG, m_end);
            end
         end
         if (k == abort_at && abort_kind == 1) begin
            IN_VALID = 1'b0;
            do_start(abort_as, abort_ast);
            return;
         end
         if (k == abort_at && abort_kind == 2) begin
            IN_VALID = 1'b0;
            nRESET = 1'b0;
            @(posedge CLK);
            @(negedge CLK);
            nRESET = 1'b1;
            model_reset();
            vectors++;
            if ({IN_READY, WR_EN, END_FLAG, BUSY, WR_ADDR, WR_DATA} !== '0) begin
               miscompares++;
               $display("FAIL reset_mid: outputs=%h required 0", {IN_READY, WR_EN, END_FLAG, BUSY, WR_ADDR, WR_DATA});
            end
            return;
         end
      end
   endtask

   task automatic test_reset();
      nRESET = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_SAMPLE = '0;
      ADDR_START = '0; ADDR_STOP = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      vectors++;
      if ({IN_READY, WR_EN, END_FLAG, BUSY} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: {IN_READY,WR_EN,END_FLAG,BUSY}=%b required 0000", {IN_READY, WR_EN, END_FLAG, BUSY});
      end
      vectors++;
      if ({WR_ADDR, WR_DATA} !== 30'h0) begin
         miscompares++;
         $display("FAIL reset_bus: WR_ADDR=%h WR_DATA=%h required 0", WR_ADDR, WR_DATA);
      end
      nRESET = 1'b1;
      model_reset();
      IN_VALID = 1'b1;
      repeat (3) @(negedge CLK);
      vectors++;
      if ({IN_READY, BUSY} !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_no_run: {IN_READY,BUSY}=%b required 00", {IN_READY, BUSY});
      end
      IN_VALID = 1'b0;
   endtask

   task automatic test_known_vectors();
      dut_wa = '0; dut_wd = '0;
      do_start(16'h1234, 16'h0300);
      do_sample(0, 0, 0, 0);
      do_sample(1000, 0, 0, 0);
      vectors++;
      if (dut_wa !== 22'h123400 || dut_wd !== 8'h07) begin
         miscompares++;
         $display("FAIL first_byte: addr=%h data=%h required 123400 07", dut_wa, dut_wd);
      end
      do_start(16'h0000, 16'h0800);
      do_sample(-1000, 0, 0, 0);
      do_sample(0, 0, 0, 0);
      vectors++;
      if (dut_wd[7:4] !== 4'hF) begin
         miscompares++;
         $display("FAIL neg_nibble: nibble=%h required f", dut_wd[7:4]);
      end
   endtask

   task automatic test_back_to_back();
      int w0;
      do_start({2'b00, 2'($urandom), 12'h100 + 12'($urandom_range(0, 255))}, 16'h0F00);
      w0 = wr_count;
      for (int i = 0; i < 20; i++) do_sample(rand_sample(), 1, 0, 0);
      IN_VALID = 1'b0;
      vectors++;
      if (wr_count - w0 !== 10) begin
         miscompares++;
         $display("FAIL b2b_writes: writes=%0d required 10", wr_count - w0);
      end
   endtask

   task automatic test_saturation();
      do_start(16'h2040, 16'h0F00);
      for (int i = 0; i < 40; i++) do_sample(32767, 0, 0, 0);
      for (int i = 0; i < 40; i++) do_sample(-32768, 0, 0, 0);
      for (int i = 0; i < 10; i++) do_sample(0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [15:0] as;
      as = 16'($urandom);
      do_start(as, {4'h0, as[11:0] ^ 12'h800});
      for (int i = 0; i < 60; i++) do_sample(rand_sample(), $urandom_range(0, 1) == 1, 0, 0);
      IN_VALID = 1'b0;
   endtask

   task automatic test_stop();
      int w0, n;
      do_start(16'h0005, 16'h0006);
      w0 = wr_count;
      n = 0;
      while (!m_end && n < 600) begin
         do_sample(rand_sample(), 0, 0, 0);
         n++;
      end
      vectors++;
      if (wr_count - w0 !== 256 || mon_last_addr !== 22'h0005FF) begin
         miscompares++;
         $display("FAIL stop_writes: writes=%0d last=%h required 256 0005ff", wr_count - w0, mon_last_addr);
      end
      IN_VALID = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         vectors++;
         if ({IN_READY, BUSY, END_FLAG} !== 3'b001) begin
            miscompares++;
            $display("FAIL stop_hold: {IN_READY,BUSY,END_FLAG}=%b required 001", {IN_READY, BUSY, END_FLAG});
         end
      end
      IN_VALID = 1'b0;
      do_start(16'h0005, 16'h0006);
   endtask

   task automatic test_wrap();
      do_start(16'h2FFF, 16'h0800);
      for (int i = 0; i < 520; i++) do_sample(rand_sample(), 0, 0, 0);
      vectors++;
      if (saw_wrap !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap: write at 200000 seen=%b required 1", saw_wrap);
      end
   endtask

   task automatic test_start_abort();
      int w0;
      dut_wa = '0;
      do_start(16'h1100, 16'h0900);
      do_sample(rand_sample(), 0, 0, 0);
      abort_as = 16'h3ABC; abort_ast = 16'h0100;
      w0 = wr_count;
      do_sample(rand_sample(), 0, 12, 1);
      repeat (3) @(negedge CLK);
      vectors++;
      if (wr_count !== w0) begin
         miscompares++;
         $display("FAIL abort_write: writes=%0d required %0d", wr_count, w0);
      end
      do_sample(rand_sample(), 0, 0, 0);
      do_sample(rand_sample(), 0, 0, 0);
      vectors++;
      if (dut_wa !== 22'h3ABC00) begin
         miscompares++;
         $display("FAIL abort_reload: addr=%h required 3abc00", dut_wa);
      end
   endtask

   task automatic test_reset_mid();
      do_start(16'h0200, 16'h0900);
      do_sample(rand_sample(), 0, 6, 2);
      repeat (3) @(negedge CLK);
      do_start(16'h0200, 16'h0900);
      for (int i = 0; i < 4; i++) do_sample(rand_sample(), 0, 0, 0);
   endtask

   task automatic test_sine();
      do_start(16'h1000, 16'h0F00);
      for (int i = 0; i < 256; i++)
         do_sample($rtoi(12000.0 * $sin(6.283185307 * i / 32.0)), 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_back_to_back();
      test_saturation();
      test_random();
      test_stop();
      test_wrap();
      test_start_abort();
      test_reset_mid();
      test_sine();
      repeat (4) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
